// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_e;

endpackage

// File: rtl/serial_adder_slice.sv
// One-bit full-adder slice shared by every bit position of the serial adder.
module serial_adder_slice (
   input  logic a_bit,
   input  logic b_bit,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Combinational sum and carry of a single bit position.
   always_comb begin
      s    = a_bit ^ b_bit ^ cin;
      cout = (a_bit & b_bit) | (a_bit & cin) | (b_bit & cin);
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH operand bits pass LSB first through one full-adder
// slice, one bit per clock, with the carry held in a flop between bits.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds the 'sub' input (a - b).
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one bit added per clock, busy high
// DONE  | one-cycle done pulse; start here re-launches immediately
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   sa_state_e        r_state;
   sa_state_e        w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_carryout;
   logic             r_overflow;
   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic             w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_b_load;
   logic             w_cin_load;

`ifdef SERIAL_ADDER_SUBTRACT_EN
   // Subtraction is a + ~b + 1; the caller's carryin is ignored then.
   always_comb begin
      w_b_load   = sub ? ~b : b;
      w_cin_load = sub ? 1'b1 : carryin;
   end
`else
   // Add-only build loads the operands unchanged.
   always_comb begin
      w_b_load   = b;
      w_cin_load = carryin;
   end
`endif

   serial_adder_slice u_slice (
      .a_bit (r_a[0]),
      .b_bit (r_b[0]),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // Next-state and datapath enables.
   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = RUN;
            end
         end
         RUN: begin
            w_shift = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = RUN;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Operand/sum shift registers, carry flop, bit counter and final flags.
   // The sum register is not cleared on load so the previous result stays
   // visible until the first RUN edge shifts in a new bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_carryout <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_load) begin
         r_a     <= a;
         r_b     <= w_b_load;
         r_carry <= w_cin_load;
         r_cnt   <= '0;
      end else if (w_shift) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_sum   <= {w_s, r_sum[WIDTH-1:1]};
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_carryout <= w_cout;
            r_overflow <= r_carry ^ w_cout;
         end
      end
   end

   assign busy     = (r_state == RUN);
   assign done     = (r_state == DONE);
   assign sum      = r_sum;
   assign carryout = r_carryout;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, random
// operands against an arithmetic model, back-to-back and reset-abort cases.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carryin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carryout;
   logic         overflow;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .carryin  (carryin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
      .sub      (sub),
`endif
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (carryout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                        input logic msub, output logic [W-1:0] es, output logic eco,
                        output logic eov);
      int unsigned bb;
      int unsigned cc;
      int unsigned tot;
      bb  = msub ? ((~int'(mb)) & 32'hFF) : int'(mb);
      cc  = msub ? 1 : int'(mcin);
      tot = int'(ma) + bb + cc;
      es  = tot[W-1:0];
      eco = tot[W];
      eov = (ma[W-1] == bb[W-1]) && (es[W-1] != ma[W-1]);
   endtask

   // Launch one operation, scramble operands after acceptance, wait for done.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         input logic tsub, output logic [W-1:0] s, output logic co,
                         output logic ov, output int lat, output int bcnt);
      @(negedge clk);
      a = ta; b = tb_v; carryin = tcin; sub = tsub; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_v; carryin = ~tcin; sub = ~tsub;
      lat = 1; bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      s = sum; co = carryout; ov = overflow;
   endtask

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic [W-1:0] esum;
      logic         eco;
      logic         eov;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [W-1:0] s, es, s0;
      logic co, ov, eco, eov;
      int lat, bcnt, t1, t2;
      logic [W-1:0] ra, rb;
      logic rc;

      vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      reset = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; carryin = 1'b1; sub = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_sum", 32'(sum), 0);
      check("reset_carryout", 32'(carryout), 0);
      check("reset_overflow", 32'(overflow), 0);
      start = 1'b0;
      reset = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, 1'b0, s, co, ov, lat, bcnt);
         check($sformatf("vec%0d_latency", i), 32'(lat), W + 1);
         check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), W);
         check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].esum));
         check($sformatf("vec%0d_carryout", i), 32'(co), 32'(vecs[i].eco));
         check($sformatf("vec%0d_overflow", i), 32'(ov), 32'(vecs[i].eov));
         s0 = s;
         repeat (3) @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
         check($sformatf("vec%0d_sum_held", i), 32'(sum), 32'(s0));
      end

      // Random operands against the model
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         model(ra, rb, rc, 1'b0, es, eco, eov);
         run_op(ra, rb, rc, 1'b0, s, co, ov, lat, bcnt);
         check("rand_latency", 32'(lat), W + 1);
         check("rand_sum", 32'(s), 32'(es));
         check("rand_carryout", 32'(co), 32'(eco));
         check("rand_overflow", 32'(ov), 32'(eov));
      end

`ifdef SERIAL_ADDER_SUBTRACT_EN
      run_op(8'h10, 8'h20, 1'b0, 1'b1, s, co, ov, lat, bcnt);
      check("sub_10_20_sum", 32'(s), 32'h0F0);
      check("sub_10_20_carryout", 32'(co), 0);
      check("sub_10_20_overflow", 32'(ov), 0);
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         model(ra, rb, rc, 1'b1, es, eco, eov);
         run_op(ra, rb, rc, 1'b1, s, co, ov, lat, bcnt);
         check("rand_sub_sum", 32'(s), 32'(es));
         check("rand_sub_carryout", 32'(co), 32'(eco));
         check("rand_sub_overflow", 32'(ov), 32'(eov));
      end
`endif

      // Back-to-back with start held high: 1+2 then 3+4
      @(negedge clk);
      a = 8'd1; b = 8'd2; carryin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'd3; b = 8'd4;
      t1 = -1; t2 = -1;
      for (int n = 1; n < 40 && t2 < 0; n++) begin
         if (done) begin
            if (t1 < 0) begin
               t1 = n;
               check("b2b_first_sum", 32'(sum), 32'h03);
            end else begin
               t2 = n;
               check("b2b_second_sum", 32'(sum), 32'h07);
               start = 1'b0;
            end
         end
         if (t2 < 0) @(negedge clk);
      end
      check("b2b_first_latency", 32'(t1), W + 1);
      check("b2b_done_spacing", 32'(t2 - t1), W + 1);
      @(negedge clk);
      @(negedge clk);
      check("b2b_idle_after", 32'(busy), 0);

      // Reset during RUN aborts with no done pulse
      @(negedge clk);
      a = 8'hAA; b = 8'h55; carryin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 0);
      check("abort_sum", 32'(sum), 0);
      check("abort_carryout", 32'(carryout), 0);
      check("abort_done", 32'(done), 0);
      reset = 1'b0;
      bcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) bcnt++;
      end
      check("abort_no_done", 32'(bcnt), 0);
      run_op(8'hAA, 8'h55, 1'b0, 1'b0, s, co, ov, lat, bcnt);
      check("abort_fresh_sum", 32'(s), 32'hFF);
      check("abort_fresh_carryout", 32'(co), 0);
      check("abort_fresh_latency", 32'(lat), W + 1);

      // Reset wins over start in the same cycle
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("reset_beats_start", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
